// File: rtl/simd_ram_arb_pkg.sv
// Shared constants and helpers for the RAM port arbiter.
package simd_ram_arb_pkg;

  // Default requester count.
  localparam int NUM_REQ_DEFAULT = 4;

  // Supported requester range.
  localparam int NUM_REQ_MIN = 2;
  localparam int NUM_REQ_MAX = 8;

  // Width of a requester index.
  // Clamped to 1 so that a degenerate count still yields a legal vector.
  function automatic int id_width(input int num_req);
    return (num_req <= 1) ? 1 : $clog2(num_req);
  endfunction

  // Low bit of slice idx in a packed bus of width-bit fields.
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

  // High bit of slice idx in a packed bus of width-bit fields.
  function automatic int slice_hi(input int idx, input int width);
    return (idx * width) + width - 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant from the requests and a
// registered priority pointer that moves to one past the last winner.
module rr_arbiter
  import simd_ram_arb_pkg::*;
#(
  parameter int N  = NUM_REQ_DEFAULT,
  parameter int PW = id_width(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  output logic [N-1:0]  gnt,
  output logic [PW-1:0] gnt_id,
  output logic          gnt_any
);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  // Scan requesters from the pointer upward, wrapping at N; first hit wins.
  // Grants are forced off while reset is high.
  always_comb begin
    int idx;
    logic found;
    gnt     = '0;
    gnt_id  = '0;
    gnt_any = 1'b0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr_reg) + k;
      if (idx >= N) begin
        idx = idx - N;
      end
      if (!found && req[idx] && !reset) begin
        found       = 1'b1;
        gnt[idx]    = 1'b1;
        gnt_id      = PW'(idx);
      end
    end
    gnt_any = found;
  end

  // Next pointer: one past the winner (wrapping), otherwise hold.
  always_comb begin
    ptr_next = ptr_reg;
    if (gnt_any) begin
      if (gnt_id == PW'(N - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = gnt_id + PW'(1);
      end
    end
  end

  // Pointer register; reset returns priority to requester 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates NUM_REQ requesters onto a single-read / single-write RAM.
// Read and write ports have independent round-robin arbiters. Read data
// returns one cycle after the grant, tagged with the granted requester.
module ram_port_arbiter
  import simd_ram_arb_pkg::*;
#(
  parameter int NUM_REQ    = NUM_REQ_DEFAULT,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                           clk,
  input  logic                           reset,
  // read requesters
  input  logic [NUM_REQ-1:0]             rd_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  rd_addr,
  output logic [NUM_REQ-1:0]             rd_gnt,
  output logic                           rd_rsp_valid,
  output logic [id_width(NUM_REQ)-1:0]   rd_rsp_id,
  output logic [DATA_WIDTH-1:0]          rd_rsp_data,
  // write requesters
  input  logic [NUM_REQ-1:0]             wr_req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  wr_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  wr_data,
  output logic [NUM_REQ-1:0]             wr_gnt,
  // RAM read port
  output logic                           ram_read_req,
  output logic [ADDR_WIDTH-1:0]          ram_read_addr,
  input  logic [DATA_WIDTH-1:0]          ram_read_data,
  // RAM write port
  output logic                           ram_write_req,
  output logic [ADDR_WIDTH-1:0]          ram_write_addr,
  output logic [DATA_WIDTH-1:0]          ram_write_data
);

  localparam int ID_W = id_width(NUM_REQ);

  logic [ID_W-1:0] rd_gnt_id;
  logic [ID_W-1:0] wr_gnt_id;
  logic            rd_gnt_any;
  logic            wr_gnt_any;

  logic            rsp_valid_reg;
  logic [ID_W-1:0] rsp_id_reg;

  // Per-requester slices, zeroed unless that requester holds the grant, so
  // the RAM-side buses are a plain OR and read as 0 when idle.
  logic [ADDR_WIDTH-1:0] rd_addr_masked [NUM_REQ];
  logic [ADDR_WIDTH-1:0] wr_addr_masked [NUM_REQ];
  logic [DATA_WIDTH-1:0] wr_data_masked [NUM_REQ];

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_rd_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (rd_req),
    .gnt     (rd_gnt),
    .gnt_id  (rd_gnt_id),
    .gnt_any (rd_gnt_any)
  );

  rr_arbiter #(
    .N  (NUM_REQ),
    .PW (ID_W)
  ) u_wr_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (wr_req),
    .gnt     (wr_gnt),
    .gnt_id  (wr_gnt_id),
    .gnt_any (wr_gnt_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign rd_addr_masked[gi] = rd_gnt[gi]
        ? rd_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH] : '0;
      assign wr_addr_masked[gi] = wr_gnt[gi]
        ? wr_addr[slice_lo(gi, ADDR_WIDTH) +: ADDR_WIDTH] : '0;
      assign wr_data_masked[gi] = wr_gnt[gi]
        ? wr_data[slice_lo(gi, DATA_WIDTH) +: DATA_WIDTH] : '0;
    end
  endgenerate

  // Collapse the masked slices onto the RAM ports.
  always_comb begin
    ram_read_addr  = '0;
    ram_write_addr = '0;
    ram_write_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ram_read_addr  = ram_read_addr  | rd_addr_masked[i];
      ram_write_addr = ram_write_addr | wr_addr_masked[i];
      ram_write_data = ram_write_data | wr_data_masked[i];
    end
  end

  assign ram_read_req  = rd_gnt_any;
  assign ram_write_req = wr_gnt_any;

  // Track which requester the RAM's next read word belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid_reg <= 1'b0;
      rsp_id_reg    <= '0;
    end else begin
      rsp_valid_reg <= rd_gnt_any;
      if (rd_gnt_any) begin
        rsp_id_reg <= rd_gnt_id;
      end
    end
  end

  // A grant issued just before reset would otherwise surface as a response
  // in the first reset cycle, so the outputs are also gated by reset.
  assign rd_rsp_valid = rsp_valid_reg & ~reset;
  assign rd_rsp_id    = reset ? '0 : rsp_id_reg;

  // The RAM already registers its output; pass it straight through.
  assign rd_rsp_data  = ram_read_data;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural read-before-write RAM.
module tb_ram_port_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 10;

  logic              clk;
  logic              reset;
  logic [N-1:0]      rd_req;
  logic [N*AW-1:0]   rd_addr;
  logic [N-1:0]      rd_gnt;
  logic              rd_rsp_valid;
  logic [1:0]        rd_rsp_id;
  logic [DW-1:0]     rd_rsp_data;
  logic [N-1:0]      wr_req;
  logic [N*AW-1:0]   wr_addr;
  logic [N*DW-1:0]   wr_data;
  logic [N-1:0]      wr_gnt;
  logic              ram_read_req;
  logic [AW-1:0]     ram_read_addr;
  logic [DW-1:0]     ram_read_data;
  logic              ram_write_req;
  logic [AW-1:0]     ram_write_addr;
  logic [DW-1:0]     ram_write_data;

  int n_checks = 0;
  int n_fail   = 0;

  ram_port_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .rd_req         (rd_req),
    .rd_addr        (rd_addr),
    .rd_gnt         (rd_gnt),
    .rd_rsp_valid   (rd_rsp_valid),
    .rd_rsp_id      (rd_rsp_id),
    .rd_rsp_data    (rd_rsp_data),
    .wr_req         (wr_req),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .wr_gnt         (wr_gnt),
    .ram_read_req   (ram_read_req),
    .ram_read_addr  (ram_read_addr),
    .ram_read_data  (ram_read_data),
    .ram_write_req  (ram_write_req),
    .ram_write_addr (ram_write_addr),
    .ram_write_data (ram_write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM: registered read, read-before-write, output 0 in reset.
  logic [DW-1:0] mem [1 << AW];
  always @(posedge clk) begin
    if (reset) begin
      ram_read_data <= '0;
    end else begin
      if (ram_read_req)  ram_read_data <= mem[ram_read_addr];
      if (ram_write_req) mem[ram_write_addr] <= ram_write_data;
    end
  end

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rd_req  = '0;
    wr_req  = '0;
    rd_addr = '0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    rd_req = 4'b1111;
    wr_req = 4'b1111;
    step();
    step();
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0000) begin
      $display("FAIL reset_rd_gnt actual=%b required=0000", rd_gnt); n_fail++;
    end
    n_checks++;
    if (wr_gnt !== 4'b0000) begin
      $display("FAIL reset_wr_gnt actual=%b required=0000", wr_gnt); n_fail++;
    end
    n_checks++;
    if ({ram_read_req, ram_write_req} !== 2'b00) begin
      $display("FAIL reset_ram_req actual=%b required=00", {ram_read_req, ram_write_req}); n_fail++;
    end
    n_checks++;
    if (rd_rsp_valid !== 1'b0 || rd_rsp_id !== 2'd0) begin
      $display("FAIL reset_rsp actual=%b/%0d required=0/0", rd_rsp_valid, rd_rsp_id); n_fail++;
    end
    clear_inputs();
    step();
    reset = 1'b0;
    $display("reset released");
  endtask

  // All four readers request continuously; grants rotate 0,1,2,3,0,...
  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    for (int i = 0; i < N; i++) rd_addr[i*AW +: AW] = AW'(16 + i);
    rd_req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      exp_gnt = 4'b0001 << (k % 4);
      $display("rr cycle %0d gnt=%b addr=%0d", k, rd_gnt, ram_read_addr);
      n_checks++;
      if (rd_gnt !== exp_gnt) begin
        $display("FAIL rr_gnt[%0d] actual=%b required=%b", k, rd_gnt, exp_gnt); n_fail++;
      end
      n_checks++;
      if (ram_read_req !== 1'b1 || ram_read_addr !== AW'(16 + (k % 4))) begin
        $display("FAIL rr_addr[%0d] actual=%0d required=%0d", k, ram_read_addr, 16 + (k % 4)); n_fail++;
      end
      if (k > 0) begin
        n_checks++;
        if (rd_rsp_valid !== 1'b1 || rd_rsp_id !== 2'((k - 1) % 4)) begin
          $display("FAIL rr_rsp[%0d] actual=%b/%0d required=1/%0d", k, rd_rsp_valid, rd_rsp_id, (k - 1) % 4); n_fail++;
        end
      end
      step();
    end
    rd_req = '0;
    #1;
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_id !== 2'd3) begin
      $display("FAIL rr_last_rsp actual=%b/%0d required=1/3", rd_rsp_valid, rd_rsp_id); n_fail++;
    end
    step();
    n_checks++;
    if (rd_rsp_valid !== 1'b0) begin
      $display("FAIL rr_drain actual=%b required=0", rd_rsp_valid); n_fail++;
    end
  endtask

  // Write 0xDEAD to address 5 from requester 2, then read it back via 1.
  task automatic test_write_then_read();
    clear_inputs();
    wr_req = 4'b0100;
    wr_addr[2*AW +: AW] = AW'(5);
    wr_data[2*DW +: DW] = 32'hDEAD;
    #1;
    $display("write gnt=%b addr=%0d data=%h", wr_gnt, ram_write_addr, ram_write_data);
    n_checks++;
    if (wr_gnt !== 4'b0100 || ram_write_req !== 1'b1) begin
      $display("FAIL wr_gnt actual=%b required=0100", wr_gnt); n_fail++;
    end
    n_checks++;
    if (ram_write_addr !== AW'(5) || ram_write_data !== 32'hDEAD) begin
      $display("FAIL wr_bus actual=%0d/%h required=5/dead", ram_write_addr, ram_write_data); n_fail++;
    end
    step();
    clear_inputs();
    rd_req = 4'b0010;
    rd_addr[1*AW +: AW] = AW'(5);
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0010) begin
      $display("FAIL wtr_rd_gnt actual=%b required=0010", rd_gnt); n_fail++;
    end
    step();
    clear_inputs();
    #1;
    $display("read rsp valid=%b id=%0d data=%h", rd_rsp_valid, rd_rsp_id, rd_rsp_data);
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_id !== 2'd1 || rd_rsp_data !== 32'hDEAD) begin
      $display("FAIL wtr_rsp actual=%b/%0d/%h required=1/1/dead", rd_rsp_valid, rd_rsp_id, rd_rsp_data); n_fail++;
    end
    step();
  endtask

  // Read and write to address 7 in the same cycle returns the old word.
  task automatic test_read_before_write();
    clear_inputs();
    wr_req = 4'b0010;
    wr_addr[1*AW +: AW] = AW'(7);
    wr_data[1*DW +: DW] = 32'hAAAA;
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0010) begin
      $display("FAIL rbw_preload_gnt actual=%b required=0010", wr_gnt); n_fail++;
    end
    step();
    clear_inputs();
    wr_req = 4'b0001;
    wr_addr[0 +: AW] = AW'(7);
    wr_data[0 +: DW] = 32'h1234;
    rd_req = 4'b1000;
    rd_addr[3*AW +: AW] = AW'(7);
    #1;
    n_checks++;
    if (wr_gnt !== 4'b0001 || rd_gnt !== 4'b1000) begin
      $display("FAIL rbw_gnts actual=%b/%b required=0001/1000", wr_gnt, rd_gnt); n_fail++;
    end
    step();
    wr_req = '0;
    #1;
    $display("rbw rsp id=%0d data=%h", rd_rsp_id, rd_rsp_data);
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_id !== 2'd3 || rd_rsp_data !== 32'hAAAA) begin
      $display("FAIL rbw_old actual=%b/%0d/%h required=1/3/aaaa", rd_rsp_valid, rd_rsp_id, rd_rsp_data); n_fail++;
    end
    step();
    rd_req = '0;
    #1;
    n_checks++;
    if (rd_rsp_valid !== 1'b1 || rd_rsp_data !== 32'h1234) begin
      $display("FAIL rbw_new actual=%b/%h required=1/1234", rd_rsp_valid, rd_rsp_data); n_fail++;
    end
    step();
  endtask

  // Requester 3 holds while 0 toggles; 3 must win within 4 cycles.
  task automatic test_starvation();
    logic got3;
    int   when3;
    clear_inputs();
    got3  = 1'b0;
    when3 = -1;
    for (int k = 0; k < 4 && !got3; k++) begin
      rd_req = {1'b1, 2'b00, (k % 2 == 0)};
      #1;
      $display("starve cycle %0d req=%b gnt=%b", k, rd_req, rd_gnt);
      if (rd_gnt[3] === 1'b1) begin
        got3  = 1'b1;
        when3 = k;
      end
      step();
    end
    n_checks++;
    if (got3 !== 1'b1 || when3 !== 1) begin
      $display("FAIL starve_bound actual=%0d required=1", when3); n_fail++;
    end
    clear_inputs();
    step();
  endtask

  // Reset right after a grant suppresses the response and re-seeds priority.
  task automatic test_reset_after_grant();
    clear_inputs();
    rd_req = 4'b0010;
    #1;
    n_checks++;
    if (rd_gnt !== 4'b0010) begin
      $display("FAIL rag_pre_gnt actual=%b required=0010", rd_gnt); n_fail++;
    end
    step();
    reset  = 1'b1;
    rd_req = '0;
    #1;
    n_checks++;
    if (rd_rsp_valid !== 1'b0 || rd_rsp_id !== 2'd0) begin
      $display("FAIL rag_rsp_in_reset actual=%b/%0d required=0/0", rd_rsp_valid, rd_rsp_id); n_fail++;
    end
    step();
    n_checks++;
    if (rd_rsp_valid !== 1'b0) begin
      $display("FAIL rag_rsp_in_reset2 actual=%b required=0", rd_rsp_valid); n_fail++;
    end
    reset  = 1'b0;
    rd_req = 4'b1010;
    #1;
    $display("post-reset gnt=%b", rd_gnt);
    n_checks++;
    if (rd_gnt !== 4'b0010) begin
      $display("FAIL rag_first_gnt actual=%b required=0010", rd_gnt); n_fail++;
    end
    step();
    rd_req = '0;
    step();
  endtask

  // Ten idle cycles: nothing granted and both pointers keep their place.
  task automatic test_idle();
    clear_inputs();
    wr_req = 4'b0100;
    step();
    clear_inputs();
    step();
    for (int k = 0; k < 10; k++) begin
      #1;
      n_checks++;
      if (rd_gnt !== 4'b0000 || wr_gnt !== 4'b0000 ||
          ram_read_req !== 1'b0 || ram_write_req !== 1'b0 ||
          ram_read_addr !== '0 || ram_write_addr !== '0 || rd_rsp_valid !== 1'b0) begin
        $display("FAIL idle[%0d] actual=%b/%b/%b%b required=0000/0000/00", k, rd_gnt, wr_gnt, ram_read_req, ram_write_req); n_fail++;
      end
      step();
    end
    rd_req = 4'b1111;
    wr_req = 4'b1111;
    #1;
    $display("after idle rd_gnt=%b wr_gnt=%b", rd_gnt, wr_gnt);
    n_checks++;
    if (rd_gnt !== 4'b0100) begin
      $display("FAIL idle_rd_ptr actual=%b required=0100", rd_gnt); n_fail++;
    end
    n_checks++;
    if (wr_gnt !== 4'b1000) begin
      $display("FAIL idle_wr_ptr actual=%b required=1000", wr_gnt); n_fail++;
    end
    step();
    clear_inputs();
    step();
  endtask

  initial begin
    reset = 1'b1;
    clear_inputs();
    test_reset();
    test_round_robin();
    test_write_then_read();
    test_read_before_write();
    test_starvation();
    test_reset_after_grant();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WIDTH, default 32, RAM word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 10, RAM address width.
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge clk.
REQ-005 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port rd_req  input  NUM_REQ  per-requester read request.
REQ-007 SHALL have port rd_addr  input  NUM_REQ*ADDR_WIDTH  packed read addresses; requester i at slice i.
REQ-008 SHALL have port rd_gnt  output  NUM_REQ  one-hot read grant.
REQ-009 SHALL have port rd_rsp_valid  output  1  read data valid.
REQ-010 SHALL have port rd_rsp_id  output  $clog2(NUM_REQ)  requester index for rd_rsp_data.
REQ-011 SHALL have port rd_rsp_data  output  DATA_WIDTH  read data.
REQ-012 SHALL have port wr_req  input  NUM_REQ  per-requester write request.
REQ-013 SHALL have port wr_addr  input  NUM_REQ*ADDR_WIDTH  packed write addresses.
REQ-014 SHALL have port wr_data  input  NUM_REQ*DATA_WIDTH  packed write data.
REQ-015 SHALL have port wr_gnt  output  NUM_REQ  one-hot write grant.
REQ-016 SHALL have ports ram_read_req/ram_read_addr  output  1/ADDR_WIDTH  to RAM read port.
REQ-017 SHALL have port ram_read_data  input  DATA_WIDTH  RAM registered read data (1-cycle latency, 0 while RAM in reset).
REQ-018 SHALL have ports ram_write_req/ram_write_addr/ram_write_data  output  1/ADDR_WIDTH/DATA_WIDTH  to RAM write port.

Function
REQ-019 Read and write ports SHALL be arbitrated independently, each round-robin.
REQ-020 Grants SHALL be combinational from current requests and priority pointer; at most one bit set per port.
REQ-021 Round-robin: search starts at pointer p, ascending modulo NUM_REQ; first requester with req=1 is granted.
REQ-022 After grant to i, pointer SHALL become (i+1) mod NUM_REQ next cycle; with no grant it SHALL hold.
REQ-023 Handshake: transfer occurs in a cycle with req=1 and gnt=1; requester holds req/addr/data stable until granted; dropping req before grant is allowed.
REQ-024 ram_read_req SHALL equal |rd_gnt; ram_read_addr SHALL be the granted slice, 0 when idle.
REQ-025 ram_write_req SHALL equal |wr_gnt; ram_write_addr/ram_write_data SHALL be the granted slices, 0 when idle.
REQ-026 rd_rsp_valid SHALL assert exactly one cycle after each read grant, with rd_rsp_id = granted index registered at grant.
REQ-027 rd_rsp_data SHALL pass ram_read_data combinationally (no extra register); total read latency grant-to-data 1 cycle.
REQ-028 Back-to-back grants SHALL yield back-to-back responses, one per cycle, in grant order.
REQ-029 Same-cycle read grant and write grant to the same address SHALL return pre-write data (RAM read-before-write); no forwarding.
REQ-030 Any requester holding req SHALL be granted within NUM_REQ cycles (starvation bound).

Reset
REQ-031 While reset=1: rd_gnt, wr_gnt, ram_*_req SHALL be 0, both pointers 0, rd_rsp_valid 0, rd_rsp_id 0.
REQ-032 A grant in the cycle before reset asserts SHALL produce no rd_rsp_valid during reset; first post-reset arbitration starts at requester 0.

Structure
REQ-033 NUM_REQ default, ID width function and packed-slice helpers SHALL live in package simd_ram_arb_pkg.
REQ-034 Round-robin logic SHALL be sub-module rr_arbiter (req, gnt, pointer update), instantiated twice.

Verification
REQ-035 rd_req=4'b1111 held 8 cycles -> rd_gnt sequence 0001,0010,0100,1000,0001,...; rd_rsp_id 0,1,2,3,... one cycle later.
REQ-036 wr_req[2]=1 addr 5 data 0xDEAD, then rd_req[1] addr 5 next cycle -> rd_rsp_valid, id 1, data 0xDEAD.
REQ-037 Same cycle wr_req[0] addr 7 data 0x1234 and rd_req[3] addr 7 (prior 0xAAAA) -> response data 0xAAAA, next read 0x1234.
REQ-038 rd_req[3] held while rd_req[0] toggles every cycle -> requester 3 granted within 4 cycles.
REQ-039 reset asserted the cycle after a read grant -> rd_rsp_valid 0 during reset; after release rd_req=4'b1010 -> first grant 0010.
REQ-040 No requests 10 cycles -> all grants 0, pointers unchanged, ram_read_req/ram_write_req 0.
